// File: rtl/mbus_tx_arbiter.sv
// Message-granular arbiter sharing one MBus TX port among NUM_REQ requesters.
// Multi-word streams stay atomic; node responses are relayed to the owner and acknowledged on its behalf.
module mbus_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_TX_ADDR,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_TX_DATA,
    input  logic [NUM_REQ-1:0]            REQ_TX_REQ,
    input  logic [NUM_REQ-1:0]            REQ_TX_PEND,
    input  logic [NUM_REQ-1:0]            REQ_TX_PRIORITY,
    output logic [NUM_REQ-1:0]            REQ_TX_ACK,
    output logic [NUM_REQ-1:0]            REQ_TX_SUCC,
    output logic [NUM_REQ-1:0]            REQ_TX_FAIL,
    input  logic [NUM_REQ-1:0]            REQ_TX_RESP_ACK,
    output logic [ADDR_WIDTH-1:0]         TX_ADDR,
    output logic [DATA_WIDTH-1:0]         TX_DATA,
    output logic                          TX_REQ,
    output logic                          TX_PEND,
    output logic                          TX_PRIORITY,
    input  logic                          TX_ACK,
    input  logic                          TX_SUCC,
    input  logic                          TX_FAIL,
    output logic                          TX_RESP_ACK,
    output logic                          GRANT_VALID,
    output logic [2:0]                    GRANT_ID
);

    typedef enum logic [2:0] {IDLE, XFER, ACKED, NEXT, RESP, RESP_ACK} state_t;

    localparam logic [2:0] LAST_ID = 3'(NUM_REQ - 1);

    state_t               state;
    logic [2:0]           rr_ptr;
    logic [2:0]           owner;
    logic [NUM_REQ-1:0]   owner_oh;
    logic                 pend_last;
    logic                 succ_flag;
    logic                 fail_flag;
    logic                 own_req;
    logic                 own_resp_ack;
    logic [NUM_REQ-1:0]   prio_hit;
    logic                 win_found;
    logic [2:0]           win_id;
    logic [NUM_REQ-1:0]   win_oh;
    int                   idx;

    assign own_req      = |(REQ_TX_REQ & owner_oh);
    assign own_resp_ack = |(REQ_TX_RESP_ACK & owner_oh);
    assign GRANT_ID     = owner;

    // Priority requests win by lowest index; otherwise the first requester at or after rr_ptr.
    always_comb begin
        prio_hit  = REQ_TX_REQ & REQ_TX_PRIORITY;
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (prio_hit[i]) begin
                win_found = 1'b1;
                win_id    = 3'(i);
            end
        end
        if (!win_found) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                if ((REQ_TX_REQ & (NUM_REQ'(1) << idx)) != '0) begin
                    win_found = 1'b1;
                    win_id    = 3'(idx);
                end
            end
        end
        win_oh = NUM_REQ'(1) << win_id;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            owner_oh    <= '0;
            pend_last   <= 1'b0;
            succ_flag   <= 1'b0;
            fail_flag   <= 1'b0;
            REQ_TX_ACK  <= '0;
            REQ_TX_SUCC <= '0;
            REQ_TX_FAIL <= '0;
            TX_ADDR     <= '0;
            TX_DATA     <= '0;
            TX_REQ      <= 1'b0;
            TX_PEND     <= 1'b0;
            TX_PRIORITY <= 1'b0;
            TX_RESP_ACK <= 1'b0;
            GRANT_VALID <= 1'b0;
        end else begin
            // The first response seen while owned sticks; the other is then ignored.
            if (state != IDLE && !succ_flag && !fail_flag) begin
                if (TX_FAIL)      fail_flag <= 1'b1;
                else if (TX_SUCC) succ_flag <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (win_found) begin
                        owner       <= win_id;
                        owner_oh    <= win_oh;
                        TX_ADDR     <= ADDR_WIDTH'(REQ_TX_ADDR >> (int'(win_id) * ADDR_WIDTH));
                        TX_DATA     <= DATA_WIDTH'(REQ_TX_DATA >> (int'(win_id) * DATA_WIDTH));
                        TX_PEND     <= |(REQ_TX_PEND & win_oh);
                        TX_PRIORITY <= |(REQ_TX_PRIORITY & win_oh);
                        TX_REQ      <= 1'b1;
                        GRANT_VALID <= 1'b1;
                        state       <= XFER;
                    end
                end
                XFER: begin
                    if (TX_FAIL) begin
                        TX_REQ <= 1'b0;
                        state  <= RESP;
                    end else if (TX_ACK) begin
                        TX_REQ     <= 1'b0;
                        REQ_TX_ACK <= owner_oh;
                        pend_last  <= TX_PEND;
                        state      <= ACKED;
                    end
                end
                ACKED: begin
                    if (!own_req && !TX_ACK) begin
                        REQ_TX_ACK <= '0;
                        state      <= pend_last ? NEXT : RESP;
                    end
                end
                NEXT: begin
                    if (TX_FAIL || fail_flag) begin
                        state <= RESP;
                    end else if (own_req) begin
                        TX_DATA <= DATA_WIDTH'(REQ_TX_DATA >> (int'(owner) * DATA_WIDTH));
                        TX_PEND <= |(REQ_TX_PEND & owner_oh);
                        TX_REQ  <= 1'b1;
                        state   <= XFER;
                    end
                end
                RESP: begin
                    if (fail_flag || (!succ_flag && TX_FAIL)) REQ_TX_FAIL <= owner_oh;
                    else if (succ_flag || TX_SUCC)            REQ_TX_SUCC <= owner_oh;
                    if (own_resp_ack && ((REQ_TX_SUCC | REQ_TX_FAIL) != '0)) begin
                        TX_RESP_ACK <= 1'b1;
                        state       <= RESP_ACK;
                    end
                end
                RESP_ACK: begin
                    if (!TX_SUCC && !TX_FAIL && !own_resp_ack) begin
                        rr_ptr      <= (owner == LAST_ID) ? 3'd0 : owner + 3'd1;
                        owner       <= '0;
                        owner_oh    <= '0;
                        pend_last   <= 1'b0;
                        succ_flag   <= 1'b0;
                        fail_flag   <= 1'b0;
                        REQ_TX_SUCC <= '0;
                        REQ_TX_FAIL <= '0;
                        TX_ADDR     <= '0;
                        TX_DATA     <= '0;
                        TX_PEND     <= 1'b0;
                        TX_PRIORITY <= 1'b0;
                        TX_RESP_ACK <= 1'b0;
                        GRANT_VALID <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mbus_tx_arbiter.sv
// Self-checking bench for mbus_tx_arbiter: scripted node and requester behaviour,
// expected grants from an arithmetic priority/round-robin model.
module tb_mbus_tx_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic [AW-1:0] req_addr [N];
    logic [DW-1:0] req_data [N];
    logic [N-1:0]  req_req, req_pend, req_prio, req_resp_ack;
    logic [N*AW-1:0] req_addr_flat;
    logic [N*DW-1:0] req_data_flat;
    logic [N-1:0]  REQ_TX_ACK, REQ_TX_SUCC, REQ_TX_FAIL;
    logic [AW-1:0] TX_ADDR;
    logic [DW-1:0] TX_DATA;
    logic          TX_REQ, TX_PEND, TX_PRIORITY, TX_RESP_ACK, GRANT_VALID;
    logic [2:0]    GRANT_ID;
    logic          tx_ack, tx_succ, tx_fail;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_addr_flat[g*AW +: AW] = req_addr[g];
        assign req_data_flat[g*DW +: DW] = req_data[g];
    end

    mbus_tx_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ_TX_ADDR(req_addr_flat), .REQ_TX_DATA(req_data_flat),
        .REQ_TX_REQ(req_req), .REQ_TX_PEND(req_pend), .REQ_TX_PRIORITY(req_prio),
        .REQ_TX_ACK(REQ_TX_ACK), .REQ_TX_SUCC(REQ_TX_SUCC), .REQ_TX_FAIL(REQ_TX_FAIL),
        .REQ_TX_RESP_ACK(req_resp_ack),
        .TX_ADDR(TX_ADDR), .TX_DATA(TX_DATA), .TX_REQ(TX_REQ), .TX_PEND(TX_PEND),
        .TX_PRIORITY(TX_PRIORITY), .TX_ACK(tx_ack), .TX_SUCC(tx_succ), .TX_FAIL(tx_fail),
        .TX_RESP_ACK(TX_RESP_ACK), .GRANT_VALID(GRANT_VALID), .GRANT_ID(GRANT_ID)
    );

    always #5 CLK = ~CLK;

    int            n_checks = 0;
    int            n_fails  = 0;
    int            rr_model = 0;
    int            m_len  [N];
    int            m_left [N];
    bit            m_prio [N];
    logic [AW-1:0] m_addr [N];
    logic [DW-1:0] m_data [N][4];

    function automatic int pick(input logic [N-1:0] pend, input logic [N-1:0] pr, input int rr);
        for (int i = 0; i < N; i++) if (pend[i] && pr[i]) return i;
        for (int k = 0; k < N; k++) if (pend[(rr + k) % N]) return (rr + k) % N;
        return -1;
    endfunction

    function automatic bit any_left();
        for (int i = 0; i < N; i++) if (m_left[i] > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic load_msg(input int r, input int len, input bit pr, input logic [AW-1:0] a);
        m_len[r]  = len;
        m_addr[r] = a;
        m_prio[r] = pr;
        for (int w = 0; w < len; w++) m_data[r][w] = $urandom;
        req_addr[r] = a;
        req_data[r] = m_data[r][0];
        req_pend[r] = (len > 1);
        req_prio[r] = pr;
        req_req[r]  = 1'b1;
    endtask

    // Runs the winning requester's whole message; fail_word<0 means no early fail.
    task automatic serve(input int fail_word, input bit final_fail, input bit pulse, output int gid);
        int exp_id, t;
        bit early, exp_succ;
        logic [N-1:0] oh;
        exp_id = pick(req_req, req_prio, rr_model);
        gid = exp_id;
        early = 1'b0;
        t = 0;
        while (!TX_REQ && t < 20) begin @(posedge CLK); #1; t++; end
        n_checks++;
        if (TX_REQ !== 1'b1 || t != 1 || GRANT_VALID !== 1'b1 || int'(GRANT_ID) != exp_id) begin
            n_fails++;
            $display("FAIL grant: tx_req=%b cycles=%0d valid=%b id=%0d, required 1/1/1/%0d",
                     TX_REQ, t, GRANT_VALID, GRANT_ID, exp_id);
            return;
        end
        oh = N'(1) << gid;
        for (int w = 0; w < m_len[gid]; w++) begin
            if (w > 0) begin
                t = 0;
                while (!TX_REQ && t < 20) begin @(posedge CLK); #1; t++; end
                n_checks++;
                if (TX_REQ !== 1'b1 || t != 1) begin
                    n_fails++;
                    $display("FAIL word_gap: tx_req=%b cycles=%0d, required 1 after 1", TX_REQ, t);
                end
            end
            n_checks++;
            if (TX_ADDR !== m_addr[gid] || TX_DATA !== m_data[gid][w] || TX_PEND !== (w < m_len[gid] - 1) ||
                TX_PRIORITY !== m_prio[gid] || int'(GRANT_ID) != gid) begin
                n_fails++;
                $display("FAIL word %0d: addr=%h data=%h pend=%b prio=%b id=%0d, required %h %h %b %b %0d",
                         w, TX_ADDR, TX_DATA, TX_PEND, TX_PRIORITY, GRANT_ID, m_addr[gid], m_data[gid][w],
                         (w < m_len[gid] - 1), m_prio[gid], gid);
            end
            if (w == fail_word) begin
                tx_fail = 1'b1;
                @(posedge CLK); #1;
                n_checks++;
                if (TX_REQ !== 1'b0 || REQ_TX_ACK !== '0) begin
                    n_fails++;
                    $display("FAIL early_fail: tx_req=%b ack=%b, required 0 0", TX_REQ, REQ_TX_ACK);
                end
                early = 1'b1;
                break;
            end
            tx_ack = 1'b1;
            t = 0;
            while (REQ_TX_ACK !== oh && t < 20) begin @(posedge CLK); #1; t++; end
            n_checks++;
            if (REQ_TX_ACK !== oh || TX_REQ !== 1'b0 || t != 1) begin
                n_fails++;
                $display("FAIL word_ack: ack=%b tx_req=%b cycles=%0d, required %b 0 1", REQ_TX_ACK, TX_REQ, t, oh);
            end
            req_req[gid] = 1'b0;
            tx_ack = 1'b0;
            if (pulse && w == m_len[gid] - 1) begin
                if (final_fail) tx_fail = 1'b1;
                else            tx_succ = 1'b1;
            end
            @(posedge CLK); #1;
            tx_succ = 1'b0;
            tx_fail = 1'b0;
            n_checks++;
            if (REQ_TX_ACK !== '0) begin
                n_fails++;
                $display("FAIL ack_release: ack=%b, required 0", REQ_TX_ACK);
            end
            if (w < m_len[gid] - 1) begin
                req_data[gid] = m_data[gid][w+1];
                req_pend[gid] = (w + 1 < m_len[gid] - 1);
                req_req[gid]  = 1'b1;
            end
        end
        req_req[gid] = 1'b0;
        if (!early && !pulse) begin
            if (final_fail) tx_fail = 1'b1;
            else            tx_succ = 1'b1;
        end
        exp_succ = !(early || final_fail);
        t = 0;
        while ((REQ_TX_SUCC | REQ_TX_FAIL) == '0 && t < 20) begin @(posedge CLK); #1; t++; end
        n_checks++;
        if (REQ_TX_SUCC !== (exp_succ ? oh : '0) || REQ_TX_FAIL !== (exp_succ ? '0 : oh) ||
            TX_REQ !== 1'b0 || t != 1) begin
            n_fails++;
            $display("FAIL response: succ=%b fail=%b tx_req=%b cycles=%0d, required succ=%b fail=%b 0 1",
                     REQ_TX_SUCC, REQ_TX_FAIL, TX_REQ, t, exp_succ ? oh : '0, exp_succ ? '0 : oh);
        end
        req_resp_ack[gid] = 1'b1;
        t = 0;
        while (!TX_RESP_ACK && t < 20) begin @(posedge CLK); #1; t++; end
        n_checks++;
        if (TX_RESP_ACK !== 1'b1 || t != 1) begin
            n_fails++;
            $display("FAIL resp_ack: tx_resp_ack=%b cycles=%0d, required 1 1", TX_RESP_ACK, t);
        end
        tx_succ = 1'b0;
        tx_fail = 1'b0;
        req_resp_ack[gid] = 1'b0;
        t = 0;
        while (GRANT_VALID && t < 20) begin @(posedge CLK); #1; t++; end
        n_checks++;
        if (GRANT_VALID !== 1'b0 || t != 1 || TX_REQ !== 1'b0 || REQ_TX_ACK !== '0 || REQ_TX_SUCC !== '0 ||
            REQ_TX_FAIL !== '0 || TX_RESP_ACK !== 1'b0 || GRANT_ID !== 3'd0) begin
            n_fails++;
            $display("FAIL release: valid=%b cycles=%0d req=%b ack=%b succ=%b fail=%b rack=%b id=%0d, required all 0 after 1",
                     GRANT_VALID, t, TX_REQ, REQ_TX_ACK, REQ_TX_SUCC, REQ_TX_FAIL, TX_RESP_ACK, GRANT_ID);
        end
        rr_model = (gid + 1) % N;
        m_left[gid]--;
        if (m_left[gid] > 0) load_msg(gid, $urandom_range(1, 3), m_prio[gid], $urandom);
        else begin
            req_prio[gid] = 1'b0;
            req_pend[gid] = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge CLK);
        #1;
        n_checks++;
        if (TX_REQ !== 1'b0 || GRANT_VALID !== 1'b0 || REQ_TX_ACK !== '0 || TX_ADDR !== '0 || TX_RESP_ACK !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_state: req=%b valid=%b ack=%b addr=%h rack=%b, required all 0",
                     TX_REQ, GRANT_VALID, REQ_TX_ACK, TX_ADDR, TX_RESP_ACK);
        end
        RESET = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        n_checks++;
        if (TX_REQ !== 1'b0 || GRANT_VALID !== 1'b0) begin
            n_fails++;
            $display("FAIL idle_no_req: req=%b valid=%b, required 0 0", TX_REQ, GRANT_VALID);
        end
    endtask

    task automatic test_single_word();
        int g;
        m_left[2] = 1;
        load_msg(2, 1, 1'b0, 32'h0000_0050);
        m_data[2][0] = 32'h1234_5678;
        req_data[2] = 32'h1234_5678;
        serve(-1, 1'b0, 1'b0, g);
    endtask

    task automatic test_round_robin();
        int g, last;
        last = -1;
        foreach (m_left[i]) m_left[i] = (i == 2) ? 0 : 3;
        load_msg(0, $urandom_range(1, 3), 1'b0, $urandom);
        load_msg(1, $urandom_range(1, 3), 1'b0, $urandom);
        load_msg(3, $urandom_range(1, 3), 1'b0, $urandom);
        for (int s = 0; s < 9; s++) begin
            serve(-1, 1'b0, $urandom_range(0, 1), g);
            n_checks++;
            if (g == last) begin
                n_fails++;
                $display("FAIL rr_repeat: granted %0d twice in a row, required a different requester", g);
            end
            last = g;
        end
    endtask

    task automatic test_priority();
        int g;
        m_left[0] = 1;
        m_left[2] = 1;
        load_msg(0, 1, 1'b0, $urandom);
        load_msg(2, 2, 1'b1, $urandom);
        serve(-1, 1'b0, 1'b0, g);
        n_checks++;
        if (g != 2) begin n_fails++; $display("FAIL prio_first: got %0d, required 2", g); end
        serve(-1, 1'b0, 1'b0, g);
        n_checks++;
        if (g != 0) begin n_fails++; $display("FAIL prio_second: got %0d, required 0", g); end
    endtask

    task automatic test_atomic_stream();
        int g;
        m_left[0] = 1;
        m_left[1] = 1;
        load_msg(1, 4, 1'b0, 32'h0000_0A10);
        load_msg(0, 1, 1'b0, $urandom);
        serve(-1, 1'b0, 1'b0, g);
        n_checks++;
        if (g != 1) begin n_fails++; $display("FAIL stream_owner: got %0d, required 1", g); end
        serve(-1, 1'b0, 1'b0, g);
        n_checks++;
        if (g != 0) begin n_fails++; $display("FAIL stream_after: got %0d, required 0", g); end
    endtask

    task automatic test_fail_paths();
        int g;
        m_left[1] = 1;
        load_msg(1, 3, 1'b0, $urandom);
        serve(1, 1'b0, 1'b0, g);
        m_left[2] = 1;
        load_msg(2, 1, 1'b0, $urandom);
        serve(-1, 1'b1, 1'b0, g);
    endtask

    task automatic test_stray_inputs();
        int g;
        tx_fail = 1'b1;
        tx_ack  = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        tx_fail = 1'b0;
        tx_ack  = 1'b0;
        tx_succ = 1'b1;
        @(posedge CLK); #1;
        tx_succ = 1'b0;
        n_checks++;
        if (TX_REQ !== 1'b0 || GRANT_VALID !== 1'b0 || REQ_TX_ACK !== '0) begin
            n_fails++;
            $display("FAIL stray_idle: req=%b valid=%b ack=%b, required 0 0 0", TX_REQ, GRANT_VALID, REQ_TX_ACK);
        end
        m_left[3] = 1;
        load_msg(3, 1, 1'b0, $urandom);
        serve(-1, 1'b0, 1'b0, g);
    endtask

    task automatic test_random();
        int g;
        foreach (m_left[i]) begin
            m_left[i] = $urandom_range(1, 4);
            load_msg(i, $urandom_range(1, 4), ($urandom_range(0, 3) == 0), $urandom);
        end
        for (int s = 0; s < 40 && any_left(); s++)
            serve(($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 2)) : -1,
                  ($urandom_range(0, 2) == 0), $urandom_range(0, 1), g);
    endtask

    task automatic test_reset_mid();
        int g, t;
        m_left[1] = 1;
        load_msg(1, 1, 1'b0, 32'h0000_00A0);
        serve(-1, 1'b0, 1'b0, g);
        m_left[1] = 1;
        load_msg(1, 2, 1'b0, 32'h0000_00A4);
        t = 0;
        while (!TX_REQ && t < 20) begin @(posedge CLK); #1; t++; end
        tx_ack = 1'b1;
        t = 0;
        while (REQ_TX_ACK == '0 && t < 20) begin @(posedge CLK); #1; t++; end
        n_checks++;
        if (REQ_TX_ACK !== 4'b0010) begin
            n_fails++;
            $display("FAIL pre_reset_ack: ack=%b, required 0010", REQ_TX_ACK);
        end
        #2 RESET = 1'b1;
        #1;
        n_checks++;
        if (TX_REQ !== 1'b0 || REQ_TX_ACK !== '0 || GRANT_VALID !== 1'b0 || TX_ADDR !== '0 ||
            TX_DATA !== '0 || TX_PEND !== 1'b0 || GRANT_ID !== 3'd0) begin
            n_fails++;
            $display("FAIL async_reset: req=%b ack=%b valid=%b addr=%h data=%h pend=%b id=%0d, required all 0",
                     TX_REQ, REQ_TX_ACK, GRANT_VALID, TX_ADDR, TX_DATA, TX_PEND, GRANT_ID);
        end
        tx_ack   = 1'b0;
        req_req  = '0;
        req_pend = '0;
        req_prio = '0;
        foreach (m_left[i]) m_left[i] = 0;
        rr_model = 0;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        m_left[1] = 1;
        m_left[3] = 1;
        load_msg(3, 1, 1'b0, $urandom);
        load_msg(1, 1, 1'b0, $urandom);
        serve(-1, 1'b0, 1'b0, g);
        n_checks++;
        if (g != 1) begin n_fails++; $display("FAIL post_reset_rr: got %0d, required 1", g); end
        serve(-1, 1'b0, 1'b0, g);
        n_checks++;
        if (g != 3) begin n_fails++; $display("FAIL post_reset_r3: got %0d, required 3", g); end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            req_addr[i] = '0;
            req_data[i] = '0;
            m_left[i]   = 0;
            m_len[i]    = 0;
            m_prio[i]   = 1'b0;
            m_addr[i]   = '0;
        end
        req_req = '0; req_pend = '0; req_prio = '0; req_resp_ack = '0;
        tx_ack = 1'b0; tx_succ = 1'b0; tx_fail = 1'b0;
        test_reset();
        test_single_word();
        test_round_robin();
        test_priority();
        test_atomic_stream();
        test_fail_paths();
        test_stray_inputs();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mbus_tx_arbiter.md
# mbus_tx_arbiter

Shares one MBus transmit port (the TX_* handshake of a bus-controller or layer-controller node) among NUM_REQ local requesters, e.g. the layer controller's interrupt-driven message engine, a DMA/memory streamer and a debug port. The arbiter grants whole messages rather than single words. Multi-word (TX_PEND) streams stay atomic. The arbiter relays TX_ACK, TX_SUCC and TX_FAIL back to the owning requester and completes the TX_RESP_ACK handshake on its behalf. It sits between the requesters and the mbus node wrapper's TX interface.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- ADDR_WIDTH, 32: MBus address width.
- DATA_WIDTH, 32: MBus data word width.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- REQ_TX_ADDR  in  NUM_REQ*ADDR_WIDTH  per-requester destination address; slice i belongs to requester i.
- REQ_TX_DATA  in  NUM_REQ*DATA_WIDTH  per-requester data word.
- REQ_TX_REQ  in  NUM_REQ  per-requester word request (level).
- REQ_TX_PEND  in  NUM_REQ  more words follow the current word.
- REQ_TX_PRIORITY  in  NUM_REQ  priority message request.
- REQ_TX_ACK  out  NUM_REQ  word accepted (level, 4-phase).
- REQ_TX_SUCC  out  NUM_REQ  message succeeded.
- REQ_TX_FAIL  out  NUM_REQ  message failed.
- REQ_TX_RESP_ACK  in  NUM_REQ  requester has consumed SUCC/FAIL.
- TX_ADDR  out  ADDR_WIDTH  to the node.
- TX_DATA  out  DATA_WIDTH  to the node.
- TX_REQ  out  1  to the node.
- TX_PEND  out  1  to the node.
- TX_PRIORITY  out  1  to the node.
- TX_ACK  in  1  from the node.
- TX_SUCC  in  1  from the node.
- TX_FAIL  in  1  from the node.
- TX_RESP_ACK  out  1  to the node.
- GRANT_VALID  out  1  a message is owned.
- GRANT_ID  out  3  index of the owner.

## Operation
States: IDLE, XFER, ACKED, NEXT, RESP, RESP_ACK.

- **IDLE → XFER.** Entered when any REQ_TX_REQ is high; the winner W is chosen in the same cycle.
  - Priority rule: the lowest index with REQ_TX_REQ & REQ_TX_PRIORITY wins.
  - Otherwise round-robin: search starts at rr_ptr and wraps from NUM_REQ-1 to 0.
  - Registered from W: ADDR (held for the whole message), DATA, PEND, PRIORITY.
  - GRANT_VALID=1 and GRANT_ID=W.
- **XFER.** TX_REQ=1 with the registered word.
  - On TX_ACK: TX_REQ←0, REQ_TX_ACK[W]←1, latch pend_last=PEND, go to ACKED.
- **ACKED.** REQ_TX_ACK[W] is held until REQ_TX_REQ[W]=0 and TX_ACK=0. It then clears.
  - If pend_last=1, go to NEXT; otherwise go to RESP.
- **NEXT.** Wait for REQ_TX_REQ[W]=1, register the new DATA and PEND, and go to XFER. ADDR is not re-sampled.
- **RESP.** Wait for the sticky SUCC/FAIL flag, then drive REQ_TX_SUCC[W] or REQ_TX_FAIL[W]=1 (level). On REQ_TX_RESP_ACK[W]=1, assert TX_RESP_ACK and go to RESP_ACK.
- **RESP_ACK.** When TX_SUCC=0 and TX_FAIL=0 and REQ_TX_RESP_ACK[W]=0: clear all outputs, set rr_ptr←(W+1) mod NUM_REQ (also after a priority grant), clear GRANT_VALID, and go to IDLE.

Rules that apply in every state:
- **Sticky SUCC/FAIL.** TX_SUCC/TX_FAIL rising in any non-IDLE state sets the sticky flag; SUCC and FAIL are exclusive.
- **Early fail.** TX_FAIL while in XFER or NEXT: drop TX_REQ and go directly to RESP with FAIL. If the requester still holds REQ_TX_REQ, REQ_TX_ACK is not given.
- **Late requesters.** Non-owners are never acknowledged. Their requests wait and are evaluated in IDLE only.
- **Withdrawal.** REQ_TX_REQ[W] dropping in XFER is ignored; the registered word is still sent.
- **Stray inputs.** TX_SUCC/TX_FAIL/TX_ACK while in IDLE are ignored.

## Timing
- **Reset.** On RESET all outputs go to 0, state=IDLE, rr_ptr=0, sticky flags are cleared. This is asynchronous and may occur mid-message; the node sees TX_REQ fall immediately.
- **Grant latency.** REQ_TX_REQ sampled high at edge n puts TX_REQ high after edge n+1 (1 cycle).
- **TX_ACK.** Sampled at edge n, TX_REQ falls and REQ_TX_ACK rises after edge n+1.
- **Inter-word gap.** The minimum gap is 1 cycle: REQ_TX_REQ[W] high in NEXT at edge n puts TX_REQ high after n+1.
- **Response relay.** TX_SUCC/TX_FAIL reach the requester 1 cycle late. TX_RESP_ACK rises 1 cycle after REQ_TX_RESP_ACK.
- **GRANT_ID.** Stable from grant until the IDLE return.
- **Back-to-back.** The next grant is possible in the cycle after the IDLE return.

## Test plan
- **Single word.** Requester 2 sends addr 32'h0000_0050, data 32'h1234_5678, PEND=0, node acks then SUCC → TX_DATA=32'h1234_5678, REQ_TX_ACK[2] pulses 4-phase, REQ_TX_SUCC[2]=1, TX_RESP_ACK completes, rr_ptr=3.
- **Round-robin.** Requesters 0, 1 and 3 request simultaneously and continuously, 3 messages each, with no priority → grant order 0,1,3,0,1,3,…, and no requester is granted twice in a row.
- **Priority override.** Requesters 0 and 2 are pending and requester 2 has PRIORITY=1, with rr_ptr=0 → 2 is granted first, then rr_ptr=3, then 0 is granted.
- **Atomic stream.** Requester 1 sends 4 words (PEND=1,1,1,0) while requester 0 requests throughout → all 4 words go out under GRANT_ID=1 with one TX_ADDR value; requester 0 is granted only after RESP_ACK.
- **Fail paths.**
  - TX_FAIL mid-stream during XFER of word 2 → TX_REQ drops, REQ_TX_FAIL[1]=1, no further words are sent.
  - TX_FAIL after the last word → REQ_TX_FAIL set.
- **Reset mid-message.** RESET asserted in ACKED → all outputs 0 asynchronously; after release, a requester 3 request is granted with rr_ptr=0 semantics.
